// File: rtl/cam_pattern_gen.sv
// Synthetic camera source: vsync/href timing and RGB444 test patterns, two bytes per pixel.
// Define CAM_PATTERN_ANIMATE_EN to scroll the pattern left four pixels per frame.
module cam_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 288,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 17,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10
) (
    input  logic        p_clock,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  mode,
    input  logic [11:0] solid_rgb,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  p_data,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int L  = 2 * H_ACTIVE + H_BLANK;
    localparam int HW = $clog2(L);
    localparam int VW = $clog2(V_SYNC + V_BACK + V_ACTIVE + V_FRONT);
    localparam int BW = H_ACTIVE / 8;
    localparam logic [HW-1:0] H_LAST  = HW'(L - 1);
    localparam logic [HW-1:0] H_BYTES = HW'(2 * H_ACTIVE);

    typedef enum logic [2:0] {IDLE, SYNC, BACK, ACTIVE, FRONT} state_t;

    state_t        state;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic [VW-1:0] vlast;
    logic [1:0]    mode_q;
    logic [11:0]   rgb_q;
    logic          line_end;
    logic          frame_end;
    logic          start_frame;
    logic          in_active;
    logic          phase;
    logic [9:0]    xa;
    logic [9:0]    xs;
    logic [5:0]    ya;
    logic [3:0]    sum_hi;
    logic [2:0]    bar;
    logic [11:0]   bar_rgb;
    logic [11:0]   pix;

    always_comb begin
        vlast = '0;
        unique case (state)
            SYNC:    vlast = VW'(V_SYNC - 1);
            BACK:    vlast = VW'(V_BACK - 1);
            ACTIVE:  vlast = VW'(V_ACTIVE - 1);
            FRONT:   vlast = VW'(V_FRONT - 1);
            default: vlast = '0;
        endcase
    end

    assign line_end    = (hcnt == H_LAST);
    assign frame_end   = (state == FRONT) && line_end && (vcnt == vlast);
    assign start_frame = en && ((state == IDLE) || frame_end);
    assign in_active   = (state == ACTIVE) && (hcnt < H_BYTES);
    assign phase       = hcnt[0];
    assign xa          = 10'(hcnt[HW-1:1]);
    assign ya          = 6'(vcnt);

`ifdef CAM_PATTERN_ANIMATE_EN
    logic [7:0]  fc_entry;
    logic [9:0]  off_q;
    logic [10:0] xs_sum;

    // Offset uses the count the new frame will carry, including the increment at FRONT end.
    assign fc_entry = frame_end ? frame_count[7:0] + 8'd1 : frame_count[7:0];
    assign xs_sum   = {1'b0, xa} + {1'b0, off_q};
    assign xs       = (int'(xs_sum) >= H_ACTIVE) ? 10'(xs_sum - 11'(H_ACTIVE))
                                                 : xs_sum[9:0];

    always_ff @(posedge p_clock or posedge rst) begin
        if (rst) begin
            off_q <= '0;
        end else if (start_frame) begin
            off_q <= 10'((int'(fc_entry) * 4) % H_ACTIVE);
        end
    end
`else
    assign xs = xa;
`endif

    always_comb begin
        bar = '0;
        for (int k = 1; k < 8; k++) begin
            if (int'(xs) >= k * BW) bar = bar + 3'd1;
        end
    end

    always_comb begin
        bar_rgb = 12'h000;
        unique case (bar)
            3'd0: bar_rgb = 12'hFFF;
            3'd1: bar_rgb = 12'hFF0;
            3'd2: bar_rgb = 12'h0FF;
            3'd3: bar_rgb = 12'h0F0;
            3'd4: bar_rgb = 12'hF0F;
            3'd5: bar_rgb = 12'hF00;
            3'd6: bar_rgb = 12'h00F;
            3'd7: bar_rgb = 12'h000;
        endcase
    end

    assign sum_hi = 4'((xs[5:0] + ya) >> 2);

    always_comb begin
        pix = rgb_q;
        unique case (mode_q)
            2'd0: pix = bar_rgb;
            2'd1: pix = {xs[5:2], ya[5:2], sum_hi};
            2'd2: pix = (xs[5] ^ ya[5]) ? 12'h000 : 12'hFFF;
            2'd3: pix = rgb_q;
        endcase
    end

    always_ff @(posedge p_clock or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            hcnt        <= '0;
            vcnt        <= '0;
            frame_count <= '0;
            mode_q      <= '0;
            rgb_q       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    hcnt <= '0;
                    vcnt <= '0;
                    if (en) state <= SYNC;
                end
                default: begin
                    hcnt <= line_end ? '0 : hcnt + HW'(1);
                    if (line_end) begin
                        vcnt <= (vcnt == vlast) ? '0 : vcnt + VW'(1);
                        if (vcnt == vlast) begin
                            unique case (state)
                                SYNC:   state <= BACK;
                                BACK:   state <= ACTIVE;
                                ACTIVE: state <= FRONT;
                                FRONT: begin
                                    frame_count <= frame_count + 16'd1;
                                    state       <= en ? SYNC : IDLE;
                                end
                                default: state <= IDLE;
                            endcase
                        end
                    end
                end
            endcase
            if (start_frame) begin
                mode_q <= mode;
                rgb_q  <= solid_rgb;
            end
        end
    end

    // Outputs trail the counters by one edge; all three streams share that lag.
    always_ff @(posedge p_clock or posedge rst) begin
        if (rst) begin
            vsync       <= 1'b0;
            href        <= 1'b0;
            p_data      <= 8'h00;
            frame_start <= 1'b0;
        end else begin
            vsync       <= (state == SYNC);
            href        <= in_active;
            p_data      <= !in_active ? 8'h00
                         : phase      ? {4'h0, pix[11:8]}
                                      : pix[7:0];
            frame_start <= (state == SYNC) && (vcnt == '0) && (hcnt == '0);
        end
    end

endmodule
